// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem memory interface.
package fpu_ss_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  localparam logic [5:0] EXC_LD_MISALIGNED = 6'd4;
  localparam logic [5:0] EXC_ST_MISALIGNED = 6'd6;

  // Per-transaction bookkeeping carried from the address phase to the response phase.
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  we;
    logic [1:0]            offset;
    logic [1:0]            size;
  } xif_mem_meta_t;

  // True when the access cannot be performed as a single aligned bus word access.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      3'd0:    mis = 1'b0;
      3'd1:    mis = offset[0];
      3'd2:    mis = (offset != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte enables for an access of the given size starting at the given byte lane.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/xif_mem_meta_fifo.sv
// Metadata FIFO tracking outstanding bus transactions in issue order.
module xif_mem_meta_fifo
  import fpu_ss_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  xif_mem_meta_t      wdata_i,
  output xif_mem_meta_t      rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  xif_mem_meta_t       mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push_ok;
  logic                pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next pointer and occupancy; a pop on an empty FIFO is discarded.
  always_comb begin
    push_ok  = push_i & ~full_o;
    pop_ok   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/xif_mem_responder_chk.sv
// Protocol checker for the XIF memory responder; observes ports only.
module xif_mem_responder_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic en_i,
  input logic x_mem_valid_i,
  input logic x_mem_req_spec_i,
  input logic x_mem_req_last_i,
  input logic data_req_i,
  input logic data_gnt_i,
  input logic data_rvalid_i
);

  logic [7:0] outstanding_q, outstanding_d;

  // Independent count of granted-but-unanswered bus transactions.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({data_req_i & data_gnt_i, data_rvalid_i & (outstanding_q != 8'd0)})
      2'b10:   outstanding_d = outstanding_q + 8'd1;
      2'b01:   outstanding_d = outstanding_q - 8'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= 8'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  a_spec_last: assert property (@(posedge clk_i) disable iff (!rst_ni || !en_i)
    x_mem_valid_i |-> (!x_mem_req_spec_i && x_mem_req_last_i));

  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni || !en_i)
    data_rvalid_i |-> (outstanding_q != 8'd0));

endmodule

// File: rtl/xif_mem_responder.sv
// Core-side CV-X-IF memory responder: XIF mem requests to OBI data port, registered results.
module xif_mem_responder
  import fpu_ss_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  x_mem_valid_i,
  output logic                  x_mem_ready_o,
  input  logic [X_ID_WIDTH-1:0] x_mem_req_id_i,
  input  logic [31:0]           x_mem_req_addr_i,
  input  logic                  x_mem_req_we_i,
  input  logic [2:0]            x_mem_req_size_i,
  input  logic [31:0]           x_mem_req_wdata_i,
  input  logic                  x_mem_req_spec_i,
  input  logic                  x_mem_req_last_i,
  output logic                  x_mem_resp_exc_o,
  output logic [5:0]            x_mem_resp_exccode_o,
  output logic                  x_mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0] x_mem_result_id_o,
  output logic [31:0]           x_mem_result_rdata_o,
  output logic                  x_mem_result_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // spec/last are only checked by the protocol checker, not used by the datapath.
  logic unused_hint_s;
  assign unused_hint_s = x_mem_req_spec_i ^ x_mem_req_last_i;

  logic             misaligned_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] unused_count_s;
  xif_mem_meta_t    push_meta_s;
  xif_mem_meta_t    head_meta_s;
  logic [31:0]      rdata_shift_s;

  logic                  result_valid_q, result_valid_d;
  logic [X_ID_WIDTH-1:0] result_id_q,    result_id_d;
  logic [31:0]           result_rdata_q, result_rdata_d;
  logic                  result_err_q,   result_err_d;

  // Request path: exception or bus access, all decided combinationally from the request.
  always_comb begin
    misaligned_s         = is_misaligned(x_mem_req_size_i, x_mem_req_addr_i[1:0]);
    data_req_o           = x_mem_valid_i & ~misaligned_s & ~fifo_full_s;
    push_s               = data_req_o & data_gnt_i;
    x_mem_resp_exc_o     = x_mem_valid_i & misaligned_s;
    x_mem_ready_o        = push_s | x_mem_resp_exc_o;
    x_mem_resp_exccode_o = 6'd0;
    if (x_mem_resp_exc_o) begin
      x_mem_resp_exccode_o = x_mem_req_we_i ? EXC_ST_MISALIGNED : EXC_LD_MISALIGNED;
    end else begin
      x_mem_resp_exccode_o = 6'd0;
    end
    data_addr_o  = {x_mem_req_addr_i[31:2], 2'b00};
    data_we_o    = x_mem_req_we_i;
    data_be_o    = byte_enable(x_mem_req_size_i[1:0], x_mem_req_addr_i[1:0]);
    data_wdata_o = x_mem_req_wdata_i << {x_mem_req_addr_i[1:0], 3'b000};
    push_meta_s.id     = x_mem_req_id_i;
    push_meta_s.we     = x_mem_req_we_i;
    push_meta_s.offset = x_mem_req_addr_i[1:0];
    push_meta_s.size   = x_mem_req_size_i[1:0];
  end

  xif_mem_meta_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (push_meta_s),
    .rdata_o (head_meta_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (unused_count_s)
  );

  // Result path: align and zero-extend load data of the oldest transaction; responses with no
  // outstanding transaction are dropped.
  always_comb begin
    pop_s          = data_rvalid_i & ~fifo_empty_s;
    rdata_shift_s  = data_rdata_i >> {head_meta_s.offset, 3'b000};
    result_valid_d = pop_s;
    result_id_d    = result_id_q;
    result_rdata_d = result_rdata_q;
    result_err_d   = result_err_q;
    if (pop_s) begin
      result_id_d  = head_meta_s.id;
      result_err_d = data_err_i;
      if (head_meta_s.we) begin
        result_rdata_d = 32'd0;
      end else begin
        case (head_meta_s.size)
          2'd0:    result_rdata_d = {24'd0, rdata_shift_s[7:0]};
          2'd1:    result_rdata_d = {16'd0, rdata_shift_s[15:0]};
          default: result_rdata_d = rdata_shift_s;
        endcase
      end
    end else begin
      result_rdata_d = result_rdata_q;
    end
  end

  // Result stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_rdata_q <= 32'd0;
      result_err_q   <= 1'b0;
    end else begin
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_rdata_q <= result_rdata_d;
      result_err_q   <= result_err_d;
    end
  end

  assign x_mem_result_valid_o = result_valid_q;
  assign x_mem_result_id_o    = result_id_q;
  assign x_mem_result_rdata_o = result_rdata_q;
  assign x_mem_result_err_o   = result_err_q;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed self-checking bench for xif_mem_responder.
module tb_xif_mem_responder;
  import fpu_ss_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  x_mem_valid_i;
  logic                  x_mem_ready_o;
  logic [X_ID_WIDTH-1:0] x_mem_req_id_i;
  logic [31:0]           x_mem_req_addr_i;
  logic                  x_mem_req_we_i;
  logic [2:0]            x_mem_req_size_i;
  logic [31:0]           x_mem_req_wdata_i;
  logic                  x_mem_req_spec_i;
  logic                  x_mem_req_last_i;
  logic                  x_mem_resp_exc_o;
  logic [5:0]            x_mem_resp_exccode_o;
  logic                  x_mem_result_valid_o;
  logic [X_ID_WIDTH-1:0] x_mem_result_id_o;
  logic [31:0]           x_mem_result_rdata_o;
  logic                  x_mem_result_err_o;
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic [31:0]           data_addr_o;
  logic                  data_we_o;
  logic [3:0]            data_be_o;
  logic [31:0]           data_wdata_o;
  logic                  data_rvalid_i;
  logic [31:0]           data_rdata_i;
  logic                  data_err_i;
  logic                  chk_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  xif_mem_responder #(.DEPTH(2)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .x_mem_valid_i        (x_mem_valid_i),
    .x_mem_ready_o        (x_mem_ready_o),
    .x_mem_req_id_i       (x_mem_req_id_i),
    .x_mem_req_addr_i     (x_mem_req_addr_i),
    .x_mem_req_we_i       (x_mem_req_we_i),
    .x_mem_req_size_i     (x_mem_req_size_i),
    .x_mem_req_wdata_i    (x_mem_req_wdata_i),
    .x_mem_req_spec_i     (x_mem_req_spec_i),
    .x_mem_req_last_i     (x_mem_req_last_i),
    .x_mem_resp_exc_o     (x_mem_resp_exc_o),
    .x_mem_resp_exccode_o (x_mem_resp_exccode_o),
    .x_mem_result_valid_o (x_mem_result_valid_o),
    .x_mem_result_id_o    (x_mem_result_id_o),
    .x_mem_result_rdata_o (x_mem_result_rdata_o),
    .x_mem_result_err_o   (x_mem_result_err_o),
    .data_req_o           (data_req_o),
    .data_gnt_i           (data_gnt_i),
    .data_addr_o          (data_addr_o),
    .data_we_o            (data_we_o),
    .data_be_o            (data_be_o),
    .data_wdata_o         (data_wdata_o),
    .data_rvalid_i        (data_rvalid_i),
    .data_rdata_i         (data_rdata_i),
    .data_err_i           (data_err_i)
  );

  xif_mem_responder_chk u_chk (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .en_i             (chk_en),
    .x_mem_valid_i    (x_mem_valid_i),
    .x_mem_req_spec_i (x_mem_req_spec_i),
    .x_mem_req_last_i (x_mem_req_last_i),
    .data_req_i       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                         input logic [2:0] size, input logic [31:0] wdata, input logic gnt);
    x_mem_valid_i     = 1'b1;
    x_mem_req_id_i    = id;
    x_mem_req_addr_i  = addr;
    x_mem_req_we_i    = we;
    x_mem_req_size_i  = size;
    x_mem_req_wdata_i = wdata;
    data_gnt_i        = gnt;
  endtask

  task automatic clear_in();
    x_mem_valid_i = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'd0;
    data_err_i    = 1'b0;
  endtask

  task automatic set_rsp(input logic [31:0] rdata, input logic err);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
  endtask

  task automatic check_result(input string tag, input logic [3:0] id, input logic [31:0] rdata,
                              input logic err);
    check_eq({tag, "_valid"}, 32'(x_mem_result_valid_o), 32'd1);
    check_eq({tag, "_id"},    32'(x_mem_result_id_o),    32'(id));
    check_eq({tag, "_rdata"}, x_mem_result_rdata_o,      rdata);
    check_eq({tag, "_err"},   32'(x_mem_result_err_o),   32'(err));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},   32'(x_mem_ready_o),        32'd0);
    check_eq({tag, "_req"},     32'(data_req_o),           32'd0);
    check_eq({tag, "_exc"},     32'(x_mem_resp_exc_o),     32'd0);
    check_eq({tag, "_exccode"}, 32'(x_mem_resp_exccode_o), 32'd0);
    check_eq({tag, "_rvalid"},  32'(x_mem_result_valid_o), 32'd0);
    check_eq({tag, "_rid"},     32'(x_mem_result_id_o),    32'd0);
    check_eq({tag, "_rdata"},   x_mem_result_rdata_o,      32'd0);
    check_eq({tag, "_rerr"},    32'(x_mem_result_err_o),   32'd0);
  endtask

  initial begin
    rst_ni           = 1'b0;
    chk_en           = 1'b1;
    x_mem_req_spec_i = 1'b0;
    x_mem_req_last_i = 1'b1;
    x_mem_req_id_i   = '0;
    x_mem_req_addr_i = 32'd0;
    x_mem_req_we_i   = 1'b0;
    x_mem_req_size_i = 3'd0;
    x_mem_req_wdata_i = 32'd0;
    clear_in();
    #3;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Load word 0x100, id 3
    @(negedge clk_i);
    set_req(4'd3, 32'h100, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("lw_req",  32'(data_req_o),    32'd1);
    check_eq("lw_rdy",  32'(x_mem_ready_o), 32'd1);
    check_eq("lw_exc",  32'(x_mem_resp_exc_o), 32'd0);
    check_eq("lw_addr", data_addr_o,        32'h100);
    check_eq("lw_be",   32'(data_be_o),     32'hF);
    check_eq("lw_we",   32'(data_we_o),     32'd0);
    @(negedge clk_i);
    clear_in();
    set_rsp(32'hDEADBEEF, 1'b0);
    #1;
    check_eq("lw_early", 32'(x_mem_result_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check_result("lw", 4'd3, 32'hDEADBEEF, 1'b0);
    @(negedge clk_i);
    clear_in();
    @(posedge clk_i); #1;
    check_eq("lw_pulse", 32'(x_mem_result_valid_o), 32'd0);

    // Load half 0x102, id 5
    @(negedge clk_i);
    set_req(4'd5, 32'h102, 1'b0, 3'd1, 32'd0, 1'b1);
    #1;
    check_eq("lh_addr", data_addr_o,    32'h100);
    check_eq("lh_be",   32'(data_be_o), 32'hC);
    @(negedge clk_i);
    clear_in();
    set_rsp(32'hABCD1234, 1'b0);
    @(posedge clk_i); #1;
    check_result("lh", 4'd5, 32'h0000ABCD, 1'b0);

    // Store byte 0xA5 to 0x203, id 6
    @(negedge clk_i);
    clear_in();
    set_req(4'd6, 32'h203, 1'b1, 3'd0, 32'h000000A5, 1'b1);
    #1;
    check_eq("sb_addr",  data_addr_o,    32'h200);
    check_eq("sb_be",    32'(data_be_o), 32'h8);
    check_eq("sb_wdata", data_wdata_o,   32'hA5000000);
    check_eq("sb_we",    32'(data_we_o), 32'd1);
    @(negedge clk_i);
    clear_in();
    set_rsp(32'h12345678, 1'b0);
    @(posedge clk_i); #1;
    check_result("sb", 4'd6, 32'd0, 1'b0);

    // Load byte 0x101, id 4
    @(negedge clk_i);
    clear_in();
    set_req(4'd4, 32'h101, 1'b0, 3'd0, 32'd0, 1'b1);
    #1;
    check_eq("lb_be", 32'(data_be_o), 32'h2);
    @(negedge clk_i);
    clear_in();
    set_rsp(32'hAABBCCDD, 1'b0);
    @(posedge clk_i); #1;
    check_result("lb", 4'd4, 32'h000000CC, 1'b0);

    // Misaligned load word 0x101
    @(negedge clk_i);
    clear_in();
    set_req(4'd2, 32'h101, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("mis_ld_rdy",  32'(x_mem_ready_o),        32'd1);
    check_eq("mis_ld_exc",  32'(x_mem_resp_exc_o),     32'd1);
    check_eq("mis_ld_code", 32'(x_mem_resp_exccode_o), 32'd4);
    check_eq("mis_ld_req",  32'(data_req_o),           32'd0);
    // Illegal size store
    @(negedge clk_i);
    set_req(4'd2, 32'h0, 1'b1, 3'd3, 32'd0, 1'b1);
    #1;
    check_eq("mis_st_exc",  32'(x_mem_resp_exc_o),     32'd1);
    check_eq("mis_st_code", 32'(x_mem_resp_exccode_o), 32'd6);
    check_eq("mis_st_req",  32'(data_req_o),           32'd0);
    @(posedge clk_i); #1;
    check_eq("mis_nores", 32'(x_mem_result_valid_o), 32'd0);
    @(negedge clk_i);
    clear_in();
    #1;
    check_eq("idle_exc", 32'(x_mem_resp_exc_o), 32'd0);

    // Depth stall: ids 1,2 issue, id 3 stalls until first response
    @(negedge clk_i);
    set_req(4'd1, 32'h10, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("d_req1", 32'(data_req_o), 32'd1);
    @(negedge clk_i);
    set_req(4'd2, 32'h14, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("d_req2", 32'(data_req_o), 32'd1);
    @(negedge clk_i);
    set_req(4'd3, 32'h18, 1'b0, 3'd2, 32'd0, 1'b1);
    set_rsp(32'h11, 1'b0);
    #1;
    check_eq("d_stall_req", 32'(data_req_o),    32'd0);
    check_eq("d_stall_rdy", 32'(x_mem_ready_o), 32'd0);
    @(posedge clk_i); #1;
    check_result("d_res1", 4'd1, 32'h11, 1'b0);
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    #1;
    check_eq("d_req3", 32'(data_req_o),    32'd1);
    check_eq("d_rdy3", 32'(x_mem_ready_o), 32'd1);
    @(posedge clk_i); #1;
    check_eq("d_gap", 32'(x_mem_result_valid_o), 32'd0);
    @(negedge clk_i);
    clear_in();
    set_rsp(32'h22, 1'b0);
    @(posedge clk_i); #1;
    check_result("d_res2", 4'd2, 32'h22, 1'b0);
    @(negedge clk_i);
    set_rsp(32'h33, 1'b1);
    @(posedge clk_i); #1;
    check_result("d_res3", 4'd3, 32'h33, 1'b1);
    @(negedge clk_i);
    clear_in();

    // Reset with two outstanding
    @(negedge clk_i);
    set_req(4'd7, 32'h20, 1'b0, 3'd2, 32'd0, 1'b1);
    @(negedge clk_i);
    set_req(4'd8, 32'h24, 1'b0, 3'd2, 32'd0, 1'b1);
    @(negedge clk_i);
    clear_in();
    rst_ni = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1'b0;
    @(negedge clk_i);
    set_rsp(32'h99, 1'b0);
    @(posedge clk_i); #1;
    check_eq("drop_valid", 32'(x_mem_result_valid_o), 32'd0);
    check_eq("drop_rdata", x_mem_result_rdata_o,      32'd0);
    @(negedge clk_i);
    clear_in();
    chk_en = 1'b1;
    set_req(4'd9, 32'h30, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("post_req9", 32'(data_req_o), 32'd1);
    @(negedge clk_i);
    set_req(4'd10, 32'h34, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("post_req10", 32'(data_req_o), 32'd1);
    @(negedge clk_i);
    set_req(4'd11, 32'h38, 1'b0, 3'd2, 32'd0, 1'b1);
    #1;
    check_eq("post_full", 32'(data_req_o), 32'd0);
    @(negedge clk_i);
    clear_in();
    set_rsp(32'h90, 1'b0);
    @(posedge clk_i); #1;
    check_result("post_res9", 4'd9, 32'h90, 1'b0);
    @(negedge clk_i);
    set_rsp(32'hA0, 1'b0);
    @(posedge clk_i); #1;
    check_result("post_res10", 4'd10, 32'hA0, 1'b0);
    @(negedge clk_i);
    clear_in();
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
